// File: rtl/mdu_pkg.sv
// Shared op encodings, FSM state type and decode helpers for the HI/LO multiply/divide unit.
package mdu_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_MADD  = 4'd2;
    localparam logic [3:0] OP_MADDU = 4'd3;
    localparam logic [3:0] OP_MSUB  = 4'd4;
    localparam logic [3:0] OP_MSUBU = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_DIVU  = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    localparam int unsigned DIV_ITERS = 32;

    typedef enum logic [1:0] {StIdle, StMulRun, StDivRun, StWrite} state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
    endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Issue/result bundle between the EX-stage decoder and the multiply/divide unit.
interface mdu_hilo_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, flush, input busy, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, hi, lo);
endinterface

// File: rtl/mdu_div_core.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes, sign-fixed output.
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        signed_i,
    input  logic        flush_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        done_o,
    output logic        div0_o
);

    logic        run_q, run_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dsr_q, dsr_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic        div0_q, div0_d;
    logic [32:0] rem_sh;

    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        negq_d = negq_q;
        negr_d = negr_q;
        div0_d = div0_q;
        // quo_q holds the shrinking dividend in its upper bits and the quotient in its lower bits
        rem_sh = {rem_q, quo_q[31]};
        if (load_i) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
            dsr_d  = (signed_i && divisor_i[31]) ? -divisor_i : divisor_i;
            negq_d = signed_i & (dividend_i[31] ^ divisor_i[31]);
            negr_d = signed_i & dividend_i[31];
            div0_d = (divisor_i == '0);
        end else if (flush_i) begin
            run_d = 1'b0;
        end else if (run_q) begin
            if (rem_sh >= {1'b0, dsr_q}) begin
                rem_d = 32'(rem_sh - {1'b0, dsr_q});
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = rem_sh[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(DIV_ITERS - 1)) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            div0_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            div0_q <= div0_d;
        end
    end

    // done marks the cycle performing the final iteration; results are settled the cycle after
    assign done_o      = run_q && (cnt_q == 5'(DIV_ITERS - 1));
    assign quotient_o  = negq_q ? -quo_q : quo_q;
    assign remainder_o = negr_q ? -rem_q : rem_q;
    assign div0_o      = div0_q;

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning HI/LO: FSM, multiply/accumulate path and commit logic.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DATA_W     = 32
) (
    input  logic       clk,
    input  logic       rst,
    mdu_hilo_if.slave  mdu_io
);

    state_e              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2:0]          mul_cnt_q, mul_cnt_d;
    logic                accept, div_load, sgn;
    logic [2*DATA_W-1:0] a_ext, b_ext, prod, acc;
    logic [31:0]         div_quo, div_rem;
    logic                div_done, div0;

    assign accept   = (state_q == StIdle) && mdu_io.start && !mdu_io.flush;
    assign div_load = accept && is_div_op(mdu_io.op);

    mdu_div_core u_div (
        .clk         (clk),
        .rst         (rst),
        .load_i      (div_load),
        .dividend_i  (mdu_io.a),
        .divisor_i   (mdu_io.b),
        .signed_i    (mdu_io.op == OP_DIV),
        .flush_i     (mdu_io.flush),
        .quotient_o  (div_quo),
        .remainder_o (div_rem),
        .done_o      (div_done),
        .div0_o      (div0)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mul_cnt_d = mul_cnt_q;
        // Sign-extending to full width makes the low 2*DATA_W bits of one multiply serve both kinds
        sgn       = is_signed_op(op_q);
        a_ext     = {{DATA_W{sgn & a_q[DATA_W-1]}}, a_q};
        b_ext     = {{DATA_W{sgn & b_q[DATA_W-1]}}, b_q};
        prod      = a_ext * b_ext;
        acc       = {hi_q, lo_q};
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (mdu_io.op == OP_MTHI) begin
                        hi_d = mdu_io.a;
                    end else if (mdu_io.op == OP_MTLO) begin
                        lo_d = mdu_io.a;
                    end else if (is_mul_op(mdu_io.op)) begin
                        state_d   = StMulRun;
                        op_d      = mdu_io.op;
                        a_d       = mdu_io.a;
                        b_d       = mdu_io.b;
                        mul_cnt_d = '0;
                    end else if (is_div_op(mdu_io.op)) begin
                        state_d = StDivRun;
                        op_d    = mdu_io.op;
                    end
                end
            end
            StMulRun: begin
                mul_cnt_d = mul_cnt_q + 3'd1;
                if (mul_cnt_q == 3'(MUL_CYCLES - 1)) state_d = StWrite;
            end
            StDivRun: begin
                if (div_done) state_d = StWrite;
            end
            StWrite: begin
                state_d = StIdle;
                if (!mdu_io.flush) begin
                    unique case (op_q)
                        OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
                        OP_MADD, OP_MADDU: {hi_d, lo_d} = acc + prod;
                        OP_MSUB, OP_MSUBU: {hi_d, lo_d} = acc - prod;
                        default: begin
                            if (!div0) begin
                                hi_d = div_rem;
                                lo_d = div_quo;
                            end
                        end
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
        if (mdu_io.flush && state_q != StIdle) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    assign mdu_io.busy = (state_q != StIdle);
    assign mdu_io.hi   = hi_q;
    assign mdu_io.lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: transaction-level HI/LO model checked every cycle plus directed literal pins.
module tb_mdu_hilo;
    import mdu_pkg::*;

    localparam int unsigned MulCycles = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_hilo_if bus ();

    mdu_hilo #(.MUL_CYCLES(MulCycles), .DATA_W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .mdu_io (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result of an op as plain arithmetic on the architectural values; acc = {hi,lo} at issue.
    function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [63:0] acc);
        longint sa, sb;
        longint unsigned ua, ub;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return 64'(ua * ub);
            OP_MADD:  return acc + 64'(sa * sb);
            OP_MADDU: return acc + 64'(ua * ub);
            OP_MSUB:  return acc - 64'(sa * sb);
            OP_MSUBU: return acc - 64'(ua * ub);
            OP_DIV: begin
                if (b == 32'd0) return acc;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                ia = $signed(a);
                ib = $signed(b);
                return {32'(ia % ib), 32'(ia / ib)};
            end
            OP_DIVU: begin
                if (b == 32'd0) return acc;
                return {a % b, a / b};
            end
            default: return acc;
        endcase
    endfunction

    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_left = 0;
    bit          m_commit = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else if (m_left > 0) begin
            if (bus.flush) begin
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1 && m_commit) begin
                    m_hi <= p_hi;
                    m_lo <= p_lo;
                end
            end
        end else if (bus.start && !bus.flush) begin
            if (bus.op == OP_MTHI) begin
                m_hi <= bus.a;
            end else if (bus.op == OP_MTLO) begin
                m_lo <= bus.a;
            end else if (bus.op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU}) begin
                m_left       <= int'(MulCycles) + 1;
                m_commit     <= 1'b1;
                {p_hi, p_lo} <= model_result(bus.op, bus.a, bus.b, {m_hi, m_lo});
            end else if (bus.op inside {OP_DIV, OP_DIVU}) begin
                m_left       <= int'(DIV_ITERS) + 1;
                m_commit     <= (bus.b != 32'd0);
                {p_hi, p_lo} <= model_result(bus.op, bus.a, bus.b, {m_hi, m_lo});
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check32("busy", {31'b0, bus.busy}, {31'b0, (m_left > 0)});
            check32("hi", bus.hi, m_hi);
            check32("lo", bus.lo, m_lo);
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h1357_9BDF;
    endtask

    task automatic wait_idle(output int n);
        bit done = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.busy) n++;
            else done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still %b after 200 cycles, expected 0", bus.busy);
        end
    endtask

    task automatic expect_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
        check32({name, "_hi"}, bus.hi, hi);
        check32({name, "_lo"}, bus.lo, lo);
    endtask

    int n;

    initial begin
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        expect_hilo("reset", 32'h0, 32'h0);
        check32("reset_busy", {31'b0, bus.busy}, 32'd0);

        issue(OP_DIVU, 32'd100, 32'd7);
        wait_idle(n);
        check32("divu_lat", n, 32'd33);
        expect_hilo("divu", 32'd2, 32'd14);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        expect_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        expect_hilo("div_wrap", 32'h0, 32'h8000_0000);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        check32("mul_lat", n, 32'd4);
        expect_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        issue(OP_MADDU, 32'd1, 32'd1);
        wait_idle(n);
        expect_hilo("maddu", 32'hFFFF_FFFE, 32'h0000_0002);

        issue(OP_MSUB, 32'd2, 32'd1);
        wait_idle(n);
        expect_hilo("msub", 32'hFFFF_FFFE, 32'h0);

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_idle(n);
        expect_hilo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // Flush during DIV_RUN, then during WRITE
        issue(OP_MTLO, 32'h1234, 32'h0);
        issue(OP_DIV, 32'd50, 32'd5);
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check32("flush_run_busy", {31'b0, bus.busy}, 32'd0);
        check32("flush_run_lo", bus.lo, 32'h1234);

        issue(OP_DIV, 32'd50, 32'd5);
        repeat (32) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check32("flush_wr_busy", {31'b0, bus.busy}, 32'd0);
        check32("flush_wr_lo", bus.lo, 32'h1234);

        // Start coinciding with flush in IDLE is dropped
        @(posedge clk);
        #1 bus.flush = 1'b1;
        issue(OP_MTHI, 32'h777, 32'h0);
        bus.flush = 1'b0;
        @(negedge clk);
        check32("flush_idle_hi", bus.hi, 32'hFFFF_FFFF);

        issue(OP_MTHI, 32'hAA, 32'h0);
        issue(OP_MTLO, 32'hBB, 32'h0);
        issue(OP_DIVU, 32'd9, 32'd0);
        wait_idle(n);
        check32("div0_lat", n, 32'd33);
        expect_hilo("div0", 32'hAA, 32'hBB);

        issue(4'hF, 32'h1, 32'h1);
        @(negedge clk);
        check32("unknown_busy", {31'b0, bus.busy}, 32'd0);

        // start held with MTHI while a multiply runs must not touch HI
        issue(OP_MULTU, 32'd2, 32'd3);
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.a     = 32'h5555;
        repeat (3) @(posedge clk);
        #1 bus.start = 1'b0;
        wait_idle(n);
        expect_hilo("busy_start", 32'h0, 32'd6);

        issue(OP_MTLO, 32'h99, 32'h0);
        issue(OP_MULT, 32'd3, 32'd5);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        expect_hilo("rst_mid", 32'h0, 32'h0);
        check32("rst_mid_busy", {31'b0, bus.busy}, 32'd0);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
